// File: rtl/full_sub_pkg.sv
// ============================================================================
// full_sub_pkg : shared bit-level borrow equation for the ripple subtractor
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package full_sub_pkg;

  // Borrow out of one bit position of a - b - bin.
  function automatic logic borrow_next(input logic a, input logic b, input logic bin);
    return (~a & b) | (~a & bin) | (b & bin);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_sub_cell.sv
// ============================================================================
// full_sub_cell : single-bit combinational full subtractor
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_sub_cell
  import full_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = borrow_next(a, b, bin);

endmodule

`default_nettype wire

// File: rtl/full_sub.sv
// ============================================================================
// full_sub : WIDTH-bit ripple-borrow subtractor with one registered stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_sub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);

  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_valid;

  assign w_borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (w_borrow[i]),
      .diff (w_diff[i]),
      .bout (w_borrow[i+1])
    );
  end

  // Result registers only load on accepted inputs, so idle-cycle inputs never disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_diff <= w_diff;
        r_bout <= w_borrow[WIDTH];
      end
    end
  end

  assign diff      = r_diff;
  assign bout      = r_bout;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_full_sub.sv
// ============================================================================
// tb_full_sub : scoreboard bench for full_sub at WIDTH = 1, 4 and 8
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_sub;

  typedef struct {
    logic [63:0] d;
    logic        b;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic       a1, b1, bin1, iv1, diff1, bout1, ov1;
  logic [3:0] a4, b4, diff4;
  logic       bin4, iv4, bout4, ov4;
  logic [7:0] a8, b8, diff8;
  logic       bin8, iv8, bout8, ov8;

  exp_t q1[$], q4[$], q8[$];
  exp_t last1, last4, last8, e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  full_sub #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .bin(bin1),
    .in_valid(iv1), .diff(diff1), .bout(bout1), .out_valid(ov1));
  full_sub #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .bin(bin4),
    .in_valid(iv4), .diff(diff4), .bout(bout4), .out_valid(ov4));
  full_sub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .bin(bin8),
    .in_valid(iv8), .diff(diff8), .bout(bout8), .out_valid(ov8));

  // Reference: plain unsigned arithmetic modulo 2^w, borrow when a < b + bin.
  function automatic exp_t model(int w, longint unsigned av, longint unsigned bv, logic cv, int c);
    exp_t r;
    longint unsigned mask;
    mask  = (64'd1 << w) - 64'd1;
    r.d   = (av - bv - 64'(cv)) & mask;
    r.b   = (av < bv + 64'(cv));
    r.cyc = c;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  task automatic drive1(logic v, logic av, logic bv, logic cv);
    iv1 = v; a1 = av; b1 = bv; bin1 = cv;
    if (v) q1.push_back(model(1, 64'(av), 64'(bv), cv, cyc));
  endtask

  task automatic drive4(logic v, logic [3:0] av, logic [3:0] bv, logic cv);
    iv4 = v; a4 = av; b4 = bv; bin4 = cv;
    if (v) q4.push_back(model(4, 64'(av), 64'(bv), cv, cyc));
  endtask

  task automatic drive8(logic v, logic [7:0] av, logic [7:0] bv, logic cv);
    iv8 = v; a8 = av; b8 = bv; bin8 = cv;
    if (v) q8.push_back(model(8, 64'(av), 64'(bv), cv, cyc));
  endtask

  task automatic rnd_all(int pct_valid);
    drive1(1'($urandom_range(0, 99) < pct_valid), 1'($urandom), 1'($urandom), 1'($urandom));
    drive4(1'($urandom_range(0, 99) < pct_valid), 4'($urandom), 4'($urandom), 1'($urandom));
    drive8(1'($urandom_range(0, 99) < pct_valid), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An entry is due once a rising edge has passed since it was issued.
  `define MON(Q, LAST, OV, D, BO, TAG) \
    if (!rst_n) begin \
      chk({TAG, "_rst_diff"}, 64'(D), 64'd0); \
      chk({TAG, "_rst_bout"}, 64'(BO), 64'd0); \
      chk({TAG, "_rst_valid"}, 64'(OV), 64'd0); \
      Q.delete(); \
      LAST.d = '0; LAST.b = 1'b0; \
    end else begin \
      chk({TAG, "_out_valid"}, 64'(OV), 64'(Q.size() > 0 && Q[0].cyc < cyc)); \
      if (OV && Q.size() > 0 && Q[0].cyc < cyc) begin \
        e = Q.pop_front(); \
        chk({TAG, "_diff"}, 64'(D), e.d); \
        chk({TAG, "_bout"}, 64'(BO), 64'(e.b)); \
        LAST = e; \
      end else if (!OV) begin \
        chk({TAG, "_hold_diff"}, 64'(D), LAST.d); \
        chk({TAG, "_hold_bout"}, 64'(BO), 64'(LAST.b)); \
      end \
    end

  always @(negedge clk) begin
    if (done) begin
      chk("w1_drained", 64'(q1.size()), 64'd0);
      chk("w4_drained", 64'(q4.size()), 64'd0);
      chk("w8_drained", 64'(q8.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else begin
      `MON(q1, last1, ov1, diff1, bout1, "w1")
      `MON(q4, last4, ov4, diff4, bout4, "w4")
      `MON(q8, last8, ov8, diff8, bout8, "w8")
    end
  end

  initial begin
    last1.d = '0; last1.b = 1'b0; last1.cyc = 0;
    last4 = last1; last8 = last1; e = last1;
    drive1(0, 0, 0, 0); drive4(0, 0, 0, 0); drive8(0, 0, 0, 0);
    repeat (3) tick();

    // Release reset and present a valid input for the very first edge.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive1(1, 1'(i >> 2), 1'(i >> 1), 1'(i));
      if (i == 0) drive8(1, 8'h00, 8'hff, 1'b1);
      else if (i == 1) drive8(1, 8'hff, 8'h00, 1'b0);
      else drive8(0, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    drive1(0, 1'($urandom), 1'($urandom), 1'($urandom));
    drive8(0, 8'($urandom), 8'($urandom), 1'($urandom));

    drive4(1, 4'd3, 4'd5, 1'b0); tick();
    drive4(1, 4'd9, 4'd4, 1'b1); tick();
    drive4(1, 4'd0, 4'hf, 1'b1); tick();
    drive4(1, 4'hf, 4'd0, 1'b0); tick();
    drive4(1, 4'd7, 4'd2, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive4(0, 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end

    for (int i = 0; i < 1000; i++) begin
      drive8(1, 8'($urandom), 8'($urandom), 1'($urandom));
      drive1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drive4(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end

    for (int i = 0; i < 200; i++) begin
      rnd_all(60);
      tick();
    end

    // Reset lands in the cycle after an accepted input: that result must vanish.
    rnd_all(100);
    tick();
    rst_n = 1'b0;
    drive1(0, 0, 0, 0); drive4(0, 0, 0, 0); drive8(0, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rnd_all(i < 5 ? 100 : 70);
      tick();
    end

    drive1(0, 0, 0, 0); drive4(0, 0, 0, 0); drive8(0, 0, 0, 0);
    repeat (3) tick();
    done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/full_sub.md
FULL_SUB -- requirements
Module: full_sub

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous and active-low, with synchronous deassertion supplied externally.
REQ-004 Port a, input, WIDTH, minuend.
REQ-005 Port b, input, WIDTH, subtrahend.
REQ-006 Port bin, input, 1, borrow-in.
REQ-007 Port in_valid, input, 1, qualifies a/b/bin in the current cycle.
REQ-008 Port diff, output, WIDTH, registered difference.
REQ-009 Port bout, output, 1, registered borrow-out.
REQ-010 Port out_valid, output, 1, high for exactly one cycle per accepted input.
REQ-011 Instantiations SHALL connect ports by name, never by position.

Function
REQ-012 Per bit i: d_i = a_i XOR b_i XOR borrow_i; borrow_(i+1) = (~a_i & b_i) | (~a_i & borrow_i) | (b_i & borrow_i); borrow_0 = bin.
REQ-013 Result SHALL equal a - b - bin modulo 2^WIDTH; bout = borrow_WIDTH, which is 1 exactly when a < b + bin as unsigned values.
REQ-014 Borrow SHALL ripple LSB to MSB combinationally; no lookahead logic is required.
REQ-015 When in_valid=1 at a rising edge, diff and bout SHALL load the computed result, and out_valid SHALL be 1 in the following cycle, giving 1-cycle latency.
REQ-016 When in_valid=0 at a rising edge, diff and bout SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 Back-to-back in_valid SHALL give one result per cycle, with no bubbles and no backpressure.
REQ-018 X/Z on a, b or bin while in_valid=0 SHALL NOT change diff or bout.
REQ-019 Boundary cases: a=0, b=all-ones, bin=1 gives diff=0, bout=1; a=all-ones, b=0, bin=0 gives diff=all-ones, bout=0.

Reset
REQ-020 While rst_n=0: diff=0, bout=0, out_valid=0, taking effect immediately without waiting for a clock edge.
REQ-021 Reset asserted in the cycle after an accepted input SHALL discard that result; out_valid SHALL stay 0.
REQ-022 The first rising edge after rst_n deasserts SHALL sample inputs normally.

Structure
REQ-023 Each bit SHALL be a sub-module full_sub_cell (ports: a, b, bin, diff, bout; purely combinational), instantiated WIDTH times through a generate loop.
REQ-024 No shared package is required; WIDTH is the only constant and is local to full_sub.
REQ-025 The output register stage SHALL reside in full_sub; full_sub_cell SHALL contain no state.

Verification
REQ-026 WIDTH=1, all 8 combinations of a/b/bin, each with in_valid=1 for one cycle. Required (diff,bout) one cycle later: 000->0,0; 001->1,1; 010->1,1; 011->0,1; 100->1,0; 101->0,0; 110->0,0; 111->1,1.
REQ-027 WIDTH=4: a=3, b=5, bin=0, in_valid=1 -> next cycle diff=14, bout=1, out_valid=1; a=9, b=4, bin=1 -> diff=4, bout=0.
REQ-028 WIDTH=4: in_valid pulsed once, then inputs changed with in_valid=0 for 3 cycles -> diff and bout hold, out_valid=0 in those cycles.
REQ-029 Assert rst_n=0 mid-stream between edges -> diff, bout and out_valid go to 0 immediately; after release the next accepted input produces a correct result.
REQ-030 WIDTH=8: random back-to-back stream of 1000 inputs -> every out_valid cycle matches a reference model of a - b - bin (mod 256, borrow) with 1-cycle latency.
